// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    DONE
  } bridge_state_t;

  localparam logic [31:0] APB_BASE  = 32'h4000D000;
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB slave responder that runs one APB SETUP/ACCESS sequence per
// single-beat AHB transfer, stretching HREADYOUT until the completer
// answers or the access times out. All outputs are registered.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_PSEL   = 2,
  parameter int unsigned PSEL_LSB   = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [3:0]            HBE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [NUM_PSEL-1:0]   PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [3:0]            PSTRB,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned IDX_W = (NUM_PSEL > 1) ? $clog2(NUM_PSEL) : 1;
  localparam logic [7:0]  TO_LIM = 8'(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  bridge_state_t state;
  logic [7:0]    cnt;

  // One-hot completer select; an index beyond NUM_PSEL decodes to all zeros.
  function automatic logic [NUM_PSEL-1:0] psel_decode(input logic [IDX_W-1:0] idx);
    logic [NUM_PSEL-1:0] dec;
    dec = '0;
    for (int unsigned i = 0; i < NUM_PSEL; i++) begin
      if (32'(idx) == i) dec[i] = 1'b1;
    end
    return dec;
  endfunction

  // Bridge sequencer: address capture, APB setup/access, completion.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      HRDATA    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PSTRB     <= '0;
      PWDATA    <= '0;
    end else begin
      case (state)
        // DONE accepts a new address phase exactly like IDLE does.
        IDLE, DONE: begin
          state     <= IDLE;
          PSEL      <= '0;
          PENABLE   <= 1'b0;
          HRESP     <= 1'b0;
          HREADYOUT <= 1'b1;
          if (HSEL) begin
            PADDR     <= HADDR & WORD_MASK;
            PWRITE    <= HWRITE;
            PSTRB     <= HWRITE ? HBE : '0;
            HREADYOUT <= 1'b0;
            if (HWRITE) begin
              state <= WDATA;
            end else begin
              state <= SETUP;
              PSEL  <= psel_decode(HADDR[PSEL_LSB +: IDX_W]);
            end
          end
        end
        WDATA: begin
          PWDATA <= HWDATA;
          PSEL   <= psel_decode(PADDR[PSEL_LSB +: IDX_W]);
          state  <= SETUP;
        end
        SETUP: begin
          cnt <= '0;
          if (|PSEL) begin
            PENABLE <= 1'b1;
            state   <= ACCESS;
          end else begin
            // No completer decoded: finish with an error, no APB cycle.
            HRESP     <= 1'b1;
            HRDATA    <= ERR_RDATA;
            HREADYOUT <= 1'b1;
            state     <= DONE;
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          if (PREADY) begin
            if (!PWRITE) HRDATA <= PRDATA;
            HRESP     <= PSLVERR;
            HREADYOUT <= 1'b1;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state     <= DONE;
          end else if ((cnt + 8'd1) == TO_LIM) begin
            HRESP     <= 1'b1;
            HRDATA    <= ERR_RDATA;
            HREADYOUT <= 1'b1;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state     <= DONE;
          end
        end
        default: begin
          state     <= IDLE;
          PSEL      <= '0;
          PENABLE   <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: a transaction-timeline model
// predicts every output each cycle; a few literal checks pin the model.
module tb_ahb_apb_bridge;
  import ahb_apb_pkg::*;

  localparam int TO = 255;
  localparam logic [15:0] BASE = APB_BASE[15:0];

  logic        HCLK, HRESETn, HSEL, HWRITE, PREADY, PSLVERR;
  logic [15:0] HADDR;
  logic [3:0]  HBE;
  logic [31:0] HWDATA, PRDATA;
  logic [31:0] HRDATA, PWDATA;
  logic        HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [1:0]  PSEL;
  logic [15:0] PADDR;
  logic [3:0]  PSTRB;

  ahb_apb_bridge #(.ADDR_WIDTH(16), .NUM_PSEL(2), .PSEL_LSB(8), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HBE(HBE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    int          start;   // address-phase cycle
    int          setup;   // APB setup cycle
    int          done;    // completion cycle
    bit          write;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    bit          tmo;
  } tr_t;

  tr_t q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  logic [31:0] last_hrdata = '0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the transaction timeline.
  always @(negedge HCLK) begin
    tr_t cur;
    bit  found;
    bit  in_apb;
    logic [31:0] exp_rd;
    bit  exp_resp;
    if (!HRESETn) begin
      last_hrdata = '0;
      chk("rst_HREADYOUT", 32'(HREADYOUT), 32'd1);
      chk("rst_HRESP", 32'(HRESP), 32'd0);
      chk("rst_HRDATA", HRDATA, 32'd0);
      chk("rst_PSEL", 32'(PSEL), 32'd0);
      chk("rst_PENABLE", 32'(PENABLE), 32'd0);
      chk("rst_PWRITE", 32'(PWRITE), 32'd0);
      chk("rst_PADDR", 32'(PADDR), 32'd0);
      chk("rst_PSTRB", 32'(PSTRB), 32'd0);
      chk("rst_PWDATA", PWDATA, 32'd0);
    end else begin
      found = 0;
      foreach (q[i]) if (cyc > q[i].start && cyc <= q[i].done) begin
        found = 1;
        cur = q[i];
      end
      exp_rd   = last_hrdata;
      exp_resp = 0;
      if (found && cyc == cur.done) begin
        exp_resp = cur.tmo | cur.err;
        if (cur.tmo) exp_rd = 32'h0;
        else if (!cur.write) exp_rd = cur.rdata;
        last_hrdata = exp_rd;
      end
      in_apb = found && cyc >= cur.setup && cyc < cur.done;
      chk("HREADYOUT", 32'(HREADYOUT), 32'(!found || cyc == cur.done));
      chk("HRESP", 32'(HRESP), 32'(exp_resp));
      chk("HRDATA", HRDATA, exp_rd);
      chk("PSEL", 32'(PSEL), in_apb ? (32'd1 << cur.addr[8]) : 32'd0);
      chk("PENABLE", 32'(PENABLE), 32'(in_apb && cyc > cur.setup));
      if (in_apb) begin
        chk("PADDR", 32'(PADDR), 32'(cur.addr & 16'hFFFC));
        chk("PWRITE", 32'(PWRITE), 32'(cur.write));
        chk("PSTRB", 32'(PSTRB), cur.write ? 32'(cur.be) : 32'd0);
        if (cur.write) chk("PWDATA", PWDATA, cur.wdata);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK); #1;
      HSEL = 0; HADDR = 16'hFFFF; HWRITE = 0; HBE = 4'hF;
      HWDATA = 32'hDEADBEEF; PREADY = 0; PSLVERR = 1; PRDATA = 32'hFFFFFFFF;
    end
  endtask

  // Issues one transfer starting in the current cycle; returns in its DONE
  // cycle. w = PREADY-low cycles in ACCESS; abort_at >= 0 pulses reset then.
  task automatic xfer(input bit wr, input logic [15:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] rd, input int w,
                      input bit err, input int abort_at);
    tr_t t;
    int  rdy;
    t.start = cyc; t.write = wr; t.addr = a; t.be = be; t.wdata = wd;
    t.rdata = rd; t.err = err; t.tmo = (w >= TO);
    t.setup = t.start + 1 + (wr ? 1 : 0);
    t.done  = t.setup + 1 + (t.tmo ? TO : w + 1);
    if (t.tmo) t.err = 0;
    q.push_back(t);
    rdy = t.setup + 1 + w;
    HSEL = 1; HADDR = a; HWRITE = wr; HBE = be; HWDATA = 32'hDEADBEEF;
    while (cyc < t.done) begin
      @(posedge HCLK); #1;
      HSEL = 0; HADDR = 16'hFFFF; HWRITE = !wr; HBE = 4'hF;
      HWDATA = (wr && cyc == t.start + 1) ? wd : 32'hDEADBEEF;
      if (abort_at >= 0 && cyc == t.setup + 1 + abort_at) begin
        HRESETn = 0;
        q.delete();
        PREADY = 0;
        #1;
        chk("abort_PSEL", 32'(PSEL), 32'd0);
        chk("abort_PENABLE", 32'(PENABLE), 32'd0);
        chk("abort_HREADYOUT", 32'(HREADYOUT), 32'd1);
        @(posedge HCLK); #1;
        HRESETn = 1;
        return;
      end
      PREADY  = (cyc == rdy);
      PRDATA  = PREADY ? rd : 32'hFFFFFFFF;
      PSLVERR = PREADY ? err : 1'b1;
    end
  endtask

  initial begin
    HRESETn = 0; HSEL = 0; HADDR = '0; HWRITE = 0; HBE = '0; HWDATA = '0;
    PRDATA = '0; PREADY = 0; PSLVERR = 0;
    idle(3);
    HRESETn = 1;
    idle(2);

    // Plain read, completer 0.
    xfer(0, BASE + 16'h0004, 4'h0, 32'h0, 32'hA5A50001, 0, 0, -1);
    chk("lit_rd_HRDATA", HRDATA, 32'hA5A50001);
    chk("lit_rd_HRESP", 32'(HRESP), 32'd0);
    chk("lit_rd_PADDR", 32'(PADDR), 32'h0000D004);
    idle(1);

    // Write to completer 1; HRDATA must be untouched.
    xfer(1, BASE + 16'h0104, 4'b0011, 32'h12345678, 32'h0, 0, 0, -1);
    chk("lit_wr_PWDATA", PWDATA, 32'h12345678);
    chk("lit_wr_PSTRB", 32'(PSTRB), 32'h3);
    chk("lit_wr_HRDATA", HRDATA, 32'hA5A50001);
    idle(1);

    // Read with 3 wait states; PSLVERR high during waits is ignored.
    xfer(0, BASE + 16'h000B, 4'h0, 32'h0, 32'h0BADF00D, 3, 0, -1);
    idle(1);

    // Completer never answers: timeout.
    xfer(0, BASE + 16'h0100, 4'h0, 32'h0, 32'h11111111, 1000, 0, -1);
    chk("lit_tmo_HRESP", 32'(HRESP), 32'd1);
    chk("lit_tmo_HRDATA", HRDATA, 32'h0);
    idle(1);

    // PREADY in the last allowed ACCESS cycle wins over the timeout.
    xfer(0, BASE + 16'h010C, 4'h0, 32'h0, 32'h13572468, TO - 1, 0, -1);
    chk("lit_edge_HRESP", 32'(HRESP), 32'd0);
    idle(1);

    // Slave error, then back-to-back read issued in DONE.
    xfer(0, BASE + 16'h0000, 4'h0, 32'h0, 32'hCAFE0001, 0, 1, -1);
    chk("lit_err_HRESP", 32'(HRESP), 32'd1);
    xfer(0, BASE + 16'h0104, 4'h0, 32'h0, 32'h76543210, 0, 0, -1);
    idle(1);

    // Write with waits and error response.
    xfer(1, BASE + 16'h00FC, 4'b1100, 32'h89ABCDEF, 32'h0, 2, 1, -1);
    idle(1);

    // Reset during ACCESS, then a normal read.
    xfer(0, BASE + 16'h0004, 4'h0, 32'h0, 32'h99999999, 1000, 0, 2);
    idle(2);
    xfer(0, BASE + 16'h0004, 4'h0, 32'h0, 32'h5555AAAA, 0, 0, -1);
    chk("lit_post_HRDATA", HRDATA, 32'h5555AAAA);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- AHB-side slave responder that converts a single-beat bus transfer into an APB SETUP/ACCESS sequence.
- Sits on slave port 3 of the system AHB interconnect (address range 0x4000D000 and up) and drives the UART and other low-speed peripherals.
- Inserts wait states through HREADYOUT until the APB completer answers or a timeout expires.
- Handles one transfer at a time; there is no pipelining of the next address phase.

Parameters:
- ADDR_WIDTH, 16, width of HADDR and PADDR.
- NUM_PSEL, 2, number of APB completers; PSEL index = HADDR[PSEL_LSB +: $clog2(NUM_PSEL)].
- PSEL_LSB, 8, lowest address bit used for completer decode.
- TIMEOUT, 255, maximum cycles spent in ACCESS before the transfer is aborted (1..255).

Ports:
- HCLK  in  1  bus clock; APB shares this clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from interconnect, qualifies the address phase.
- HADDR  in  ADDR_WIDTH  byte address, address phase.
- HWRITE  in  1  1=write, 0=read, address phase.
- HBE  in  4  byte enables, address phase.
- HWDATA  in  32  write data, valid in the cycle after the address phase.
- HRDATA  out  32  read data, valid while HREADYOUT=1 in state DONE.
- HREADYOUT  out  1  0 = wait state inserted; 1 = idle or transfer complete.
- HRESP  out  1  error response, valid only with HREADYOUT=1 in DONE.
- PSEL  out  NUM_PSEL  one-hot APB completer select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address, word aligned (bits [1:0] forced to 0).
- PSTRB  out  4  byte strobes; HBE on writes, 0 on reads.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB completer ready.
- PSLVERR  in  1  APB completer error.

Behaviour:
- Reset (HRESETn=0, asynchronous):
  - State = IDLE; HREADYOUT=1; HRESP=0; HRDATA=0.
  - PSEL=0; PENABLE=0; PWRITE=0; PADDR=0; PSTRB=0; PWDATA=0; timeout counter=0.
  - Reset mid-transfer abandons the APB access immediately; no completion is reported.
- All outputs are registered.
- States:
  - IDLE: HREADYOUT=1. If HSEL=1 at a posedge, latch HADDR, HWRITE and HBE. Go to WDATA if write, else SETUP.
  - WDATA (write only, one cycle): HREADYOUT=0. Latch HWDATA at the posedge, then go to SETUP.
  - SETUP (one cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PSTRB/PWDATA stable. Clear counter, then go to ACCESS.
  - ACCESS: PSEL held, PENABLE=1, counter increments each cycle.
    - PREADY=1: capture PRDATA (reads only) and HRESP<=PSLVERR, then go to DONE.
    - Counter==TIMEOUT with PREADY=0: HRESP<=1, HRDATA<=0, then go to DONE.
    - PREADY takes priority over timeout when both occur in the same cycle.
  - DONE (one cycle): PSEL=0, PENABLE=0, HREADYOUT=1, HRDATA/HRESP valid. Next state is IDLE.
    - An HSEL=1 seen in DONE is treated exactly as in IDLE: it starts the next transfer.
- HSEL=1 in WDATA, SETUP or ACCESS is ignored; the interconnect must not issue while HREADYOUT=0.
- Latency with PREADY tied high:
  - Read: address phase at N; HREADYOUT low N+1..N+2; DONE at N+3.
  - Write: address phase at N; DONE at N+4.
- HRDATA holds its last value outside DONE. A write completion leaves HRDATA unchanged.
- PSEL index out of range (idx >= NUM_PSEL): no APB cycle is run. Go from SETUP directly to DONE with HRESP=1 and HRDATA=0.
- PWDATA and PSTRB hold their values throughout SETUP and ACCESS; PSLVERR is sampled only when PREADY=1.

Decomposition:
- Package ahb_apb_pkg:
  - typedef enum bridge_state_t {IDLE, WDATA, SETUP, ACCESS, DONE}.
  - localparam constants: APB_BASE = 32'h4000D000 and ERR_RDATA = 32'h0.
- The timeout counter stays inline; no sub-module.

Test Plan:
- Read, PREADY=1, PRDATA=0xA5A5_0001, HADDR=0xD004 -> PSEL=01 and PADDR=0xD004 in SETUP at N+1; PENABLE=1 at N+2; HRDATA=0xA5A5_0001, HRESP=0, HREADYOUT=1 at N+3.
- Write HADDR=0xD104, HBE=4'b0011, HWDATA=0x1234_5678 -> PSEL=10, PSTRB=0011, PWDATA=0x1234_5678 in SETUP at N+2; DONE at N+4.
- Read with PREADY low for 3 ACCESS cycles -> HREADYOUT stays 0 and PENABLE stays 1 throughout; DONE is entered the cycle after PREADY rises.
- PREADY never asserted, TIMEOUT=255 -> DONE after 255 ACCESS cycles with HRESP=1 and HRDATA=0.
- PSLVERR=1 with PREADY=1 -> HRESP=1 for exactly one cycle; back-to-back HSEL=1 in DONE starts a new SETUP 1 cycle later (read).
- HRESETn pulsed low during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 immediately; next read completes normally.
